job_sequencer: RTL and testbench

JOB_SEQUENCER -- requirements
Module: job_sequencer

---
 rtl/job_sequencer.sv | 130 +++++++++++++
 tb/tb_job_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/job_sequencer.sv
// job_sequencer: runs a batch of jobs over a start/done handshake and queues each result in a show-ahead FIFO.
module job_sequencer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        go_i,
  input  logic [3:0]  num_jobs_i,
  output logic        start_o,
  input  logic        done_i,
  input  logic [31:0] acc_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o,
  output logic        fifo_empty_o,
  output logic        fifo_full_o,
  output logic        busy_o,
  output logic        all_done_o,
  output logic        timeout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_STALL, S_ERROR} state_t;
  state_t state_q, state_d;
  logic start_q, start_d, busy_q, busy_d, all_done_q, all_done_d, timeout_q, timeout_d;
  logic empty_q, empty_d, full_q, full_d, push, pop;
  logic [3:0] rem_q, rem_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] hold_q, hold_d, rd_data_q, rd_data_d, wdata;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] mem_q [DEPTH];
  always_comb begin
    pop = rd_en_i && !empty_q;
    push = 1'b0;
    state_d = state_q;
    start_d = start_q;
    rem_d = rem_q;
    wcnt_d = wcnt_q;
    hold_d = hold_q;
    timeout_d = timeout_q;
    all_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (go_i) begin
        timeout_d = 1'b0;
        if (num_jobs_i != 4'd0) begin
          rem_d = num_jobs_i;
          state_d = S_LAUNCH;
        end else all_done_d = 1'b1;
      end
      S_LAUNCH: begin
        start_d = 1'b1;
        wcnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (done_i) begin
        start_d = 1'b0;
        if (!full_q || rd_en_i) push = 1'b1;
        else begin
          hold_d = acc_i;
          state_d = S_STALL;
        end
      end else if (wcnt_q == WAIT_LAST) begin
        start_d = 1'b0;
        timeout_d = 1'b1;
        state_d = S_ERROR;
      end else wcnt_d = wcnt_q + 16'd1;
      S_STALL: push = !full_q || rd_en_i;
      default: state_d = S_IDLE;
    endcase
    // every push retires one job, whether it came straight from done_i or from the hold register
    if (push) begin
      rem_d = rem_q - 4'd1;
      all_done_d = rem_q == 4'd1;
      state_d = rem_q == 4'd1 ? S_IDLE : S_LAUNCH;
    end
    busy_d = state_d != S_IDLE;
    wdata = state_q == S_STALL ? hold_q : acc_i;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    full_d = count_d == CW'(DEPTH);
    empty_d = count_d == '0;
    rd_data_d = (push && count_q == CW'(pop)) ? wdata : empty_d ? rd_data_q : mem_q[rd_ptr_d];
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      all_done_q <= 1'b0;
      timeout_q <= 1'b0;
      rem_q <= '0;
      wcnt_q <= '0;
      hold_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      busy_q <= busy_d;
      all_done_q <= all_done_d;
      timeout_q <= timeout_d;
      rem_q <= rem_d;
      wcnt_q <= wcnt_d;
      hold_q <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q <= full_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
  assign start_o = start_q;
  assign busy_o = busy_q;
  assign all_done_o = all_done_q;
  assign timeout_o = timeout_q;
  assign rd_data_o = rd_data_q;
  assign fifo_empty_o = empty_q;
  assign fifo_full_o = full_q;
endmodule

// File: tb/tb_job_sequencer.sv
// tb_job_sequencer: directed checks of job launch, result FIFO, stall, timeout and reset behaviour.
module tb_job_sequencer;
  logic clk_i = 1'b0, rstn_i = 1'b0, go_i = 1'b0, done_i = 1'b0, rd_en_i = 1'b0;
  logic [3:0] num_jobs_i = '0;
  logic [31:0] acc_i = '0, rd_data_o;
  logic start_o, fifo_empty_o, fifo_full_o, busy_o, all_done_o, timeout_o;
  int total = 0, bad = 0;
  job_sequencer #(.TIMEOUT_CYC(8), .DEPTH(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .go_i(go_i), .num_jobs_i(num_jobs_i),
    .start_o(start_o), .done_i(done_i), .acc_i(acc_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .busy_o(busy_o), .all_done_o(all_done_o), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start;
    int n = 0;
    while (start_o !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("start_seen", start_o, 1);
  endtask
  task automatic job(input logic [31:0] val, input int lat, input logic rd);
    wait_start;
    repeat (lat) tick;
    chk("start_held", start_o, 1);
    done_i = 1'b1;
    acc_i = val;
    rd_en_i = rd;
    tick;
    done_i = 1'b0;
    rd_en_i = 1'b0;
    chk("start_drop", start_o, 0);
  endtask
  task automatic pop_chk(input logic [31:0] exp);
    chk("rd_data", rd_data_o, exp);
    rd_en_i = 1'b1;
    tick;
    rd_en_i = 1'b0;
  endtask
  initial begin
    int n;
    go_i = 1'b1;
    num_jobs_i = 4'd3;
    @(posedge clk_i);
    #1;
    chk("rst_start", start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_empty", fifo_empty_o, 1);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_all_done", all_done_o, 0);
    #6 rstn_i = 1'b1;
    tick;
    go_i = 1'b0;
    chk("first_go_busy", busy_o, 1);
    chk("launch_start", start_o, 0);
    job(32'd10, 5, 1'b0);
    chk("j1_all_done", all_done_o, 0);
    job(32'd20, 5, 1'b0);
    chk("j2_all_done", all_done_o, 0);
    job(32'd30, 5, 1'b0);
    chk("j3_all_done", all_done_o, 1);
    chk("j3_busy", busy_o, 0);
    tick;
    chk("j3_pulse_end", all_done_o, 0);
    chk("j3_not_empty", fifo_empty_o, 0);
    pop_chk(32'd10);
    pop_chk(32'd20);
    pop_chk(32'd30);
    chk("drained_empty", fifo_empty_o, 1);
    chk("drained_data", rd_data_o, 32'd30);
    rd_en_i = 1'b1;
    tick;
    rd_en_i = 1'b0;
    chk("empty_pop_data", rd_data_o, 32'd30);
    chk("empty_pop_empty", fifo_empty_o, 1);
    go_i = 1'b1;
    num_jobs_i = 4'd0;
    tick;
    go_i = 1'b0;
    chk("zero_all_done", all_done_o, 1);
    chk("zero_busy", busy_o, 0);
    chk("zero_start", start_o, 0);
    tick;
    chk("zero_pulse_end", all_done_o, 0);
    go_i = 1'b1;
    num_jobs_i = 4'd6;
    tick;
    go_i = 1'b0;
    job(32'd101, 2, 1'b0);
    job(32'd102, 2, 1'b0);
    job(32'd103, 2, 1'b0);
    job(32'd104, 2, 1'b0);
    chk("six_full", fifo_full_o, 1);
    chk("six_all_done4", all_done_o, 0);
    job(32'd105, 2, 1'b0);
    repeat (3) tick;
    chk("stall_busy", busy_o, 1);
    chk("stall_start", start_o, 0);
    chk("stall_full", fifo_full_o, 1);
    chk("stall_head", rd_data_o, 32'd101);
    rd_en_i = 1'b1;
    tick;
    chk("stall_pop1_data", rd_data_o, 32'd102);
    chk("stall_pop1_full", fifo_full_o, 1);
    tick;
    rd_en_i = 1'b0;
    chk("stall_pop2_data", rd_data_o, 32'd103);
    chk("stall_pop2_full", fifo_full_o, 0);
    job(32'd106, 2, 1'b0);
    chk("six_all_done", all_done_o, 1);
    chk("six_full_end", fifo_full_o, 1);
    tick;
    pop_chk(32'd103);
    pop_chk(32'd104);
    pop_chk(32'd105);
    pop_chk(32'd106);
    chk("six_empty", fifo_empty_o, 1);
    go_i = 1'b1;
    num_jobs_i = 4'd5;
    tick;
    go_i = 1'b0;
    job(32'd201, 2, 1'b0);
    job(32'd202, 2, 1'b0);
    job(32'd203, 2, 1'b0);
    job(32'd204, 2, 1'b0);
    job(32'd205, 2, 1'b1);
    chk("pp_full", fifo_full_o, 1);
    chk("pp_all_done", all_done_o, 1);
    chk("pp_busy", busy_o, 0);
    chk("pp_head", rd_data_o, 32'd202);
    tick;
    pop_chk(32'd202);
    pop_chk(32'd203);
    pop_chk(32'd204);
    pop_chk(32'd205);
    chk("pp_empty", fifo_empty_o, 1);
    go_i = 1'b1;
    num_jobs_i = 4'd2;
    tick;
    go_i = 1'b0;
    tick;
    go_i = 1'b1;
    num_jobs_i = 4'd5;
    n = 0;
    while (start_o === 1'b1 && n < 40) begin
      n++;
      tick;
      go_i = 1'b0;
    end
    chk("to_start_cycles", n, 8);
    chk("to_flag", timeout_o, 1);
    chk("to_busy_err", busy_o, 1);
    done_i = 1'b1;
    acc_i = 32'd99;
    tick;
    done_i = 1'b0;
    chk("to_busy_fall", busy_o, 0);
    chk("to_sticky", timeout_o, 1);
    chk("to_done_ignored", fifo_empty_o, 1);
    tick;
    chk("to_still_idle", busy_o, 0);
    chk("to_sticky2", timeout_o, 1);
    go_i = 1'b1;
    num_jobs_i = 4'd1;
    tick;
    go_i = 1'b0;
    chk("to_cleared", timeout_o, 0);
    chk("mid_busy", busy_o, 1);
    wait_start;
    go_i = 1'b1;
    num_jobs_i = 4'd5;
    repeat (2) tick;
    go_i = 1'b0;
    job(32'd77, 1, 1'b0);
    chk("mid_all_done", all_done_o, 1);
    chk("mid_busy_fall", busy_o, 0);
    tick;
    chk("mid_no_relaunch", busy_o, 0);
    chk("mid_start", start_o, 0);
    pop_chk(32'd77);
    chk("mid_empty", fifo_empty_o, 1);
    go_i = 1'b1;
    num_jobs_i = 4'd4;
    tick;
    go_i = 1'b0;
    job(32'd5, 2, 1'b0);
    job(32'd6, 2, 1'b0);
    wait_start;
    repeat (2) tick;
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_start", start_o, 0);
    chk("arst_empty", fifo_empty_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_rd_data", rd_data_o, 0);
    @(posedge clk_i);
    #3 rstn_i = 1'b1;
    go_i = 1'b1;
    num_jobs_i = 4'd2;
    tick;
    go_i = 1'b0;
    job(32'd11, 2, 1'b0);
    chk("re_all_done1", all_done_o, 0);
    job(32'd12, 2, 1'b0);
    chk("re_all_done2", all_done_o, 1);
    tick;
    pop_chk(32'd11);
    pop_chk(32'd12);
    chk("re_empty", fifo_empty_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
